// File: rtl/f1_light_ctrl.sv
// f1_light_ctrl: F1 start-light sequencer; fills lights one per tick, holds for an LFSR-derived
// number of ticks, then blanks the bar with a one-cycle done pulse.
module f1_light_ctrl #(
    parameter int TICK_DIV  = 24,
    parameter int NLIGHTS   = 8,
    parameter int LFSR_W    = 4,
    parameter int MIN_DELAY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger,
    input  logic               abort,
    input  logic [LFSR_W-1:0]  lfsr_data,
    output logic               lfsr_en,
    output logic [NLIGHTS-1:0] data_out,
    output logic               busy,
    output logic               done
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LIGHTS = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = LFSR_W + 1;

    logic [1:0]         state;
    logic [TW-1:0]      tick_cnt;
    logic [DW-1:0]      delay_cnt;
    logic [NLIGHTS-1:0] lit_nxt;
    logic               tick;

    assign lfsr_en = state == IDLE;
    assign tick    = tick_cnt == TW'(TICK_DIV - 1) && state != IDLE;
    assign lit_nxt = {data_out[NLIGHTS-2:0], 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            data_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tick_cnt  <= '0;
            delay_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                data_out  <= '0;
                busy      <= 1'b0;
                tick_cnt  <= '0;
                delay_cnt <= '0;
            end else begin
                tick_cnt <= (state == IDLE || tick) ? '0 : tick_cnt + TW'(1);
                case (state)
                    IDLE: begin
                        state <= trigger ? LIGHTS : IDLE;
                        busy  <= trigger;
                    end
                    LIGHTS: if (tick) begin
                        data_out <= lit_nxt;
                        if (&lit_nxt) begin
                            state     <= HOLD;
                            delay_cnt <= DW'(lfsr_data) + DW'(MIN_DELAY);
                        end
                    end
                    HOLD: if (tick) begin
                        // a zero count (MIN_DELAY=0, lfsr=0) finishes like a count of one
                        if (delay_cnt > DW'(1)) begin
                            delay_cnt <= delay_cnt - DW'(1);
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            data_out <= '0;
                            done     <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_f1_light_ctrl.sv
// tb_f1_light_ctrl: scoreboard bench; a run-level model queues expected light/done events and
// per-edge busy, and a negedge monitor compares them against the DUT.
module tb_f1_light_ctrl;
    localparam int TD = 4;
    localparam int NL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       trigger = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] lfsr_data = 4'd0;
    logic       lfsr_en;
    logic [7:0] data_out;
    logic       busy;
    logic       done;

    f1_light_ctrl #(.TICK_DIV(TD), .NLIGHTS(NL), .LFSR_W(4), .MIN_DELAY(1)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .lfsr_data(lfsr_data),
        .lfsr_en(lfsr_en), .data_out(data_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {int e; logic [7:0] d; logic dn;} ev_t;
    typedef struct {int e; logic b;} bs_t;
    ev_t eq[$];
    bs_t bq[$];
    int  ecnt = 0;
    int  total = 0;
    int  bad = 0;
    bit  mon_on = 0;
    logic [7:0] prev_d = 8'd0;

    // run-level model: start edge, finish edge, whether a run is in flight
    bit act = 0;
    int k = 0;
    int fin = 0;

    always @(posedge clk) ecnt++;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h want %0h", nm, ecnt, got, want);
        end
    endtask

    task automatic push_ev(input int e, input logic [7:0] d, input logic dn);
        ev_t v;
        v.e = e; v.d = d; v.dn = dn;
        eq.push_back(v);
    endtask

    // drives inputs for the next edge and predicts what that edge produces
    task automatic step(input logic t, input logic a, input logic [3:0] l);
        int e, n;
        bs_t b;
        @(negedge clk);
        trigger = t; abort = a; lfsr_data = l;
        e = ecnt + 1;
        n = e - k;
        if (a) begin
            if (act && n > TD) push_ev(e, 8'd0, 1'b0);
            act = 0;
        end else if (act) begin
            if (n % TD == 0 && n / TD >= 1 && n / TD <= NL)
                push_ev(e, 8'((1 << (n / TD)) - 1), 1'b0);
            if (n == NL * TD) fin = e + (int'(l) + 1) * TD;
            if (n > NL * TD && e == fin) begin
                push_ev(e, 8'd0, 1'b1);
                act = 0;
            end
        end else if (t) begin
            act = 1;
            k = e;
            fin = 0;
        end
        b.e = e; b.b = act;
        bq.push_back(b);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            while (bq.size() > 0 && bq[0].e <= ecnt) begin
                if (bq[0].e == ecnt) begin
                    chk("busy", busy, bq[0].b);
                    chk("lfsr_en", lfsr_en, !bq[0].b);
                end
                void'(bq.pop_front());
            end
            while (eq.size() > 0 && eq[0].e < ecnt) begin
                chk("missed_event_edge", ecnt, eq[0].e);
                void'(eq.pop_front());
            end
            if (data_out !== prev_d || done !== 1'b0) begin
                if (eq.size() > 0 && eq[0].e == ecnt) begin
                    chk("data_out", data_out, eq[0].d);
                    chk("done", done, eq[0].dn);
                    void'(eq.pop_front());
                end else begin
                    chk("unexpected_event", {23'd0, done, data_out}, {24'd0, prev_d});
                end
            end
        end
        prev_d = data_out;
    end

    initial begin
        #1;
        chk("rst_data", data_out, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_lfsr_en", lfsr_en, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mon_on = 1;
        // full run with ignored triggers mid-LIGHTS and mid-HOLD
        step(1, 0, 5);
        for (int i = 1; i <= 60; i++) step(i == 10 || i == 40, 0, 5);
        // abort once five lights are on, then silence
        step(1, 0, 3);
        for (int i = 1; i <= 80; i++) step(0, i == 21, 3);
        // abort beats trigger in IDLE
        step(1, 1, 9);
        for (int i = 0; i < 5; i++) step(0, 0, 9);
        // shortest and longest hold
        step(1, 0, 0);
        for (int i = 0; i < 45; i++) step(0, 0, 0);
        step(1, 0, 15);
        for (int i = 0; i < 105; i++) step(0, 0, 15);
        // trigger held: back-to-back runs restart in the done cycle
        for (int i = 0; i < 130; i++) step(1, 0, 2);
        for (int i = 0; i < 50; i++) step(0, 0, 2);
        // asynchronous reset in the middle of LIGHTS
        step(1, 0, 7);
        for (int i = 0; i < 14; i++) step(0, 0, 7);
        @(posedge clk);
        #1;
        mon_on = 0;
        rst = 1'b0;
        #1;
        chk("midrst_data", data_out, 8'd0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_lfsr_en", lfsr_en, 1'b1);
        eq.delete();
        bq.delete();
        act = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mon_on = 1;
        for (int i = 0; i < 2000; i++)
            step($urandom % 16 == 0, $urandom % 200 == 0, 4'($urandom));
        for (int i = 0; i < 110; i++) step(0, 0, 4'($urandom));
        repeat (2) @(negedge clk);
        chk("drain_events", eq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
